// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-requester memory arbiter.
//   state_t : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   owner_t : which requester owns the transaction in flight
//   WORD_W  : address / data word width
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch
// (i_*) and load/store (d_*). One transaction is in flight at a time:
// IDLE (grant) -> ISSUE (m_req) -> WAIT (LATENCY cycles) -> RESP (rvalid).
// Data requests win, except that once STARVE_LIMIT consecutive data grants
// have been made while fetch was waiting, the next grant goes to fetch.
//
// Handshake: a requester raises req and holds its request fields stable
// until it sees gnt high in a cycle (gnt is a combinational one-cycle pulse
// in IDLE). The request is accepted at the clock edge ending that cycle.
// The response is a one-cycle rvalid pulse with rdata, LATENCY+2 cycles
// after the grant. There is no back-pressure on the response side.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   i_req/i_addr               fetch request (read only)
//   i_gnt/i_rvalid/i_rdata     fetch grant and response
//   d_req/d_we/d_addr/d_wdata  data request
//   d_gnt/d_rvalid/d_rdata     data grant and response (rdata 0 on a write)
//   m_req/m_we/m_addr/m_wdata  memory strobe and request fields
//   m_rdata                    memory read data
//   fsm_state                  current FSM state, for observation
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [WORD_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,

    output logic              m_req,
    output logic              m_we,
    output logic [WORD_W-1:0] m_addr,
    output logic [WORD_W-1:0] m_wdata,
    input  logic [WORD_W-1:0] m_rdata,

    output state_t            fsm_state
);

    localparam int LAT_W    = $clog2(LATENCY + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(LATENCY);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_t              state_q;
    state_t              state_d;
    owner_t              owner_q;
    logic [WORD_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                we_q;
    logic [WORD_W-1:0]   i_rdata_q;
    logic [WORD_W-1:0]   d_rdata_q;
    logic [LAT_W-1:0]    lat_q;
    logic [STARVE_W-1:0] starve_q;

    logic                pick_i;
    logic                pick_d;
    logic                lat_last;
    logic                starve_full;

    assign lat_last    = (lat_q == LAT_W'(1));
    assign starve_full = (starve_q == STARVE_MAX);

    // Next state and arbitration decision.
    always_comb begin
        state_d = state_q;
        pick_i  = 1'b0;
        pick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    // Data wins unless fetch is waiting and the guard has tripped.
                    if (d_req && !(i_req && starve_full)) begin
                        pick_d = 1'b1;
                    end else begin
                        pick_i = 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (lat_last) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            lat_q     <= '0;
            starve_q  <= '0;
        end else begin
            state_q <= state_d;

            if (pick_d) begin
                owner_q <= OWN_D;
                addr_q  <= d_addr;
                we_q    <= d_we;
                wdata_q <= d_wdata;
                // Only grants that bypass a waiting fetch count toward starvation.
                if (i_req) begin
                    if (!starve_full) begin
                        starve_q <= starve_q + STARVE_W'(1);
                    end
                end else begin
                    starve_q <= '0;
                end
            end else if (pick_i) begin
                owner_q  <= OWN_I;
                addr_q   <= i_addr;
                we_q     <= 1'b0;      // fetch never writes
                wdata_q  <= '0;
                starve_q <= '0;
            end

            if (state_q == ISSUE) begin
                lat_q <= LAT_LOAD;
            end else if (state_q == WAIT) begin
                lat_q <= lat_q - LAT_W'(1);
            end

            // Capture the memory word in the last WAIT cycle into the owner's
            // response register; it then holds until that owner's next response.
            if ((state_q == WAIT) && lat_last) begin
                if (owner_q == OWN_I) begin
                    i_rdata_q <= m_rdata;
                end else begin
                    d_rdata_q <= we_q ? '0 : m_rdata;
                end
            end
        end
    end

    // Grants are combinational from IDLE; masking with reset keeps them low
    // while reset is asserted even if a requester holds req high.
    assign i_gnt = pick_i & reset;
    assign d_gnt = pick_d & reset;

    assign m_req   = (state_q == ISSUE);
    assign m_we    = m_req & we_q;
    assign m_addr  = m_req ? addr_q  : '0;
    assign m_wdata = m_req ? wdata_q : '0;

    assign i_rvalid = (state_q == RESP) && (owner_q == OWN_I);
    assign d_rvalid = (state_q == RESP) && (owner_q == OWN_D);
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

    assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- main DUT (LATENCY=2, STARVE_LIMIT=4) ----------------
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    state_t      fsm_state;

    mem_arbiter #(.LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .fsm_state(fsm_state)
    );

    // Memory model: unwritten words read as 0xA0000000 | word index.
    // Read data is registered on the strobe edge, valid from the next cycle.
    logic [31:0] mem [int];
    logic [7:0]  mem_idx;
    always @(posedge clk) begin
        if (m_req) begin
            mem_idx = m_addr[9:2];
            if (m_we) mem[int'(mem_idx)] = m_wdata;
            m_rdata <= mem.exists(int'(mem_idx)) ? mem[int'(mem_idx)] : (32'hA000_0000 | {24'h0, mem_idx});
        end
    end

    // ---------------- sweep DUTs (LATENCY = 1, 3, 8), fetch only ----------------
    logic        s_i_req;
    logic [31:0] s_i_addr;
    logic        s_i_gnt [3];
    logic        s_i_rvalid [3];
    logic [31:0] s_i_rdata [3];
    logic        s_d_gnt [3];
    logic        s_d_rvalid [3];
    logic [31:0] s_d_rdata [3];
    logic        s_m_req [3];
    logic        s_m_we [3];
    logic [31:0] s_m_addr [3];
    logic [31:0] s_m_wdata [3];
    logic [31:0] s_m_rdata [3];
    logic [31:0] s_raddr [3];
    state_t      s_state [3];

    for (genvar g = 0; g < 3; g++) begin : gen_sw
        mem_arbiter #(.LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 8)), .STARVE_LIMIT(4)) u_sw (
            .clk(clk), .reset(reset),
            .i_req(s_i_req), .i_addr(s_i_addr), .i_gnt(s_i_gnt[g]),
            .i_rvalid(s_i_rvalid[g]), .i_rdata(s_i_rdata[g]),
            .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
            .d_gnt(s_d_gnt[g]), .d_rvalid(s_d_rvalid[g]), .d_rdata(s_d_rdata[g]),
            .m_req(s_m_req[g]), .m_we(s_m_we[g]), .m_addr(s_m_addr[g]),
            .m_wdata(s_m_wdata[g]), .m_rdata(s_m_rdata[g]),
            .fsm_state(s_state[g])
        );
        always @(posedge clk) if (s_m_req[g]) s_raddr[g] <= s_m_addr[g];
        assign s_m_rdata[g] = s_raddr[g] ^ 32'hC0DE_0000;
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Protocol monitors on the main DUT.
    int gnt_both = 0, rv_both = 0, m_leak = 0, d_rv_cnt = 0;
    always @(negedge clk) begin
        if (i_gnt && d_gnt) gnt_both <= gnt_both + 1;
        if (i_rvalid && d_rvalid) rv_both <= rv_both + 1;
        if (!m_req && (m_we || m_addr != 32'h0 || m_wdata != 32'h0)) m_leak <= m_leak + 1;
        if (d_rvalid) d_rv_cnt <= d_rv_cnt + 1;
    end

    // ---------------- driver ----------------
    // Called #1 after a rising edge. Raises one request, drops it after its
    // grant, and returns #1 after the edge following the response.
    // Cycle numbers are relative to the cycle the request is raised in.
    task automatic run_txn(input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata,
                           output int gk, output int mk, output logic [31:0] maddr,
                           output logic mwe, output logic [31:0] mwd,
                           output int rk, output logic [31:0] rd);
        gk = -1; mk = -1; rk = -1; maddr = 0; mwe = 0; mwd = 0; rd = 0;
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1; i_addr = addr;
        end
        for (int k = 0; k < 24 && rk < 0; k++) begin
            @(negedge clk);
            if ((is_d ? d_gnt : i_gnt) && gk < 0) gk = k;
            if (m_req && mk < 0) begin
                mk = k; maddr = m_addr; mwe = m_we; mwd = m_wdata;
            end
            if (is_d ? d_rvalid : i_rvalid) begin
                rk = k; rd = is_d ? d_rdata : i_rdata;
            end
            @(posedge clk); #1;
            if (gk >= 0) begin
                if (is_d) d_req = 0; else i_req = 0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    int gk, mk, rk;
    logic [31:0] maddr, mwd, rd;
    logic mwe;
    int sg[3], sm[3], sr[3], srv_cnt[3], sdact[3];
    logic [31:0] sa[3], srd[3];
    logic swe[3];

    initial begin
        reset = 0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        s_i_req = 0; s_i_addr = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we}, 0);
        chk("reset_data", {i_rdata, d_rdata}, 0);
        chk("reset_state", fsm_state, IDLE);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;

        // Lone fetch on LATENCY = 1, 3, 8
        for (int n = 0; n < 3; n++) begin
            sg[n] = -1; sm[n] = -1; sr[n] = -1; srv_cnt[n] = 0; sdact[n] = 0;
            sa[n] = 0; srd[n] = 0; swe[n] = 1;
        end
        s_i_req = 1; s_i_addr = 32'h40;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                if (s_i_gnt[n] && sg[n] < 0) sg[n] = k;
                if (s_m_req[n] && sm[n] < 0) begin
                    sm[n] = k; sa[n] = s_m_addr[n]; swe[n] = s_m_we[n];
                end
                if (s_i_rvalid[n]) begin
                    if (sr[n] < 0) begin sr[n] = k; srd[n] = s_i_rdata[n]; end
                    srv_cnt[n]++;
                end
                if (s_d_gnt[n] || s_d_rvalid[n]) sdact[n]++;
            end
            @(posedge clk); #1;
            if (sg[0] >= 0) s_i_req = 0;
        end
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("sw%0d_gnt", n), sg[n], 0);
            chk($sformatf("sw%0d_mreq", n), sm[n], 1);
            chk($sformatf("sw%0d_maddr", n), sa[n], 32'h40);
            chk($sformatf("sw%0d_mwe", n), swe[n], 0);
            chk($sformatf("sw%0d_rvalid_cyc", n), sr[n], (n == 0) ? 3 : (n == 1) ? 5 : 10);
            chk($sformatf("sw%0d_rdata", n), srd[n], 32'hC0DE_0040);
            chk($sformatf("sw%0d_rvalid_cnt", n), srv_cnt[n], 1);
            chk($sformatf("sw%0d_d_idle", n), sdact[n], 0);
        end

        // Data write then read, LATENCY=2
        run_txn(1, 1, 32'h100, 32'hDEAD_BEEF, gk, mk, maddr, mwe, mwd, rk, rd);
        chk("wr_gnt", gk, 0);
        chk("wr_mreq", mk, 1);
        chk("wr_maddr", maddr, 32'h100);
        chk("wr_mwe", mwe, 1);
        chk("wr_mwdata", mwd, 32'hDEAD_BEEF);
        chk("wr_rvalid_cyc", rk, 4);
        chk("wr_rdata", rd, 0);
        run_txn(1, 0, 32'h100, 32'h0, gk, mk, maddr, mwe, mwd, rk, rd);
        chk("rd_gnt", gk, 0);
        chk("rd_mwe", mwe, 0);
        chk("rd_rvalid_cyc", rk, 4);
        chk("rd_rdata", rd, 32'hDEAD_BEEF);

        // Simultaneous requests, guard clear: data first, fetch at next IDLE
        begin
            int dg, ig, ir;
            logic [31:0] idat;
            dg = -1; ig = -1; ir = -1; idat = 0;
            d_req = 1; d_we = 0; d_addr = 32'h100;
            i_req = 1; i_addr = 32'h40;
            for (int k = 0; k < 30 && ir < 0; k++) begin
                @(negedge clk);
                if (d_gnt && dg < 0) dg = k;
                if (i_gnt && ig < 0) ig = k;
                if (i_rvalid) begin ir = k; idat = i_rdata; end
                @(posedge clk); #1;
                if (dg >= 0) d_req = 0;
                if (ig >= 0) i_req = 0;
            end
            chk("sim_d_gnt", dg, 0);
            chk("sim_i_gnt", ig, 5);
            chk("sim_i_rvalid_cyc", ir, 9);
            chk("sim_i_rdata", idat, 32'hA000_0010);
        end

        // Starvation, both held continuously
        begin
            logic [9:0] pat;
            int ngr, g0, g1;
            pat = 10'b1111011110;   // 1 = data grant, 0 = fetch grant
            for (int i = 9; i >= 0; i--) exp_q.push_back(pat[i] ? "D" : "I");
            ngr = 0; g0 = -1; g1 = -1;
            d_req = 1; d_we = 0; d_addr = 32'h100;
            i_req = 1; i_addr = 32'h40;
            for (int k = 0; k < 200 && ngr < 10; k++) begin
                @(negedge clk);
                if (d_gnt || i_gnt) begin
                    chk($sformatf("starve_order%0d", ngr), d_gnt ? "D" : "I", exp_q.pop_front());
                    if (ngr == 0) g0 = k;
                    if (ngr == 1) g1 = k;
                    ngr++;
                end
                @(posedge clk); #1;
            end
            d_req = 0; i_req = 0;
            chk("starve_count", ngr, 10);
            chk("starve_spacing", g1 - g0, 5);
            repeat (6) @(posedge clk);
            #1;
        end

        // Reset in the WAIT cycle of a data read
        begin
            int rv_base;
            d_req = 1; d_we = 0; d_addr = 32'h100;
            @(negedge clk);
            chk("rst_txn_gnt", d_gnt, 1);
            @(posedge clk); #1;       // ISSUE
            d_req = 0;
            @(posedge clk); #1;       // WAIT
            reset = 0;
            @(negedge clk);
            chk("rst_mid_ctl", {i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we}, 0);
            chk("rst_mid_d_rdata", d_rdata, 0);
            chk("rst_mid_i_rdata", i_rdata, 0);
            chk("rst_mid_state", fsm_state, IDLE);
            rv_base = d_rv_cnt;
            @(posedge clk); #1;
            reset = 1;
            repeat (8) @(posedge clk);
            #1;
            chk("rst_no_rvalid", d_rv_cnt - rv_base, 0);
            run_txn(0, 0, 32'h80, 32'h0, gk, mk, maddr, mwe, mwd, rk, rd);
            chk("post_rst_gnt", gk, 0);
            chk("post_rst_mreq", mk, 1);
            chk("post_rst_maddr", maddr, 32'h80);
            chk("post_rst_rvalid_cyc", rk, 4);
            chk("post_rst_rdata", rd, 32'hA000_0020);
        end

        repeat (2) @(posedge clk);
        chk("gnt_exclusive", gnt_both, 0);
        chk("rvalid_exclusive", rv_both, 0);
        chk("m_fields_idle_zero", m_leak, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported, fixed-latency memory between the instruction-fetch path and the load/store path of the multi-cycle core. Each requester gets a request/grant/response handshake, and the arbiter sequences exactly one memory transaction at a time through a small state machine. Data accesses have priority, and a starvation guard bounds the fetch stall.

## Interface
- LATENCY, 1, memory read latency in cycles from the `m_req` cycle to valid `m_rdata`; legal range ≥1.
- STARVE_LIMIT, 4, number of consecutive data grants made while fetch is pending before fetch is forced; legal range ≥1.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- i_req  in  1  fetch request; held with `i_addr` until `i_gnt`.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  one-cycle pulse: fetch request accepted.
- i_rvalid  out  1  one-cycle pulse: `i_rdata` valid.
- i_rdata  out  32  fetched word.
- d_req  in  1  data request; held with `d_we`, `d_addr` and `d_wdata` until `d_gnt`.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: read data valid, or write acknowledged.
- d_rdata  out  32  read word; 0 on a write acknowledge.
- m_req  out  1  one-cycle memory strobe.
- m_we  out  1  write enable; qualified by `m_req`.
- m_addr  out  32  byte address passed through unchanged; the memory does the word indexing.
- m_wdata  out  32  write data.
- m_rdata  in  32  memory read data.

## Operation
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - If any request is pending, choose an owner, pulse that owner's gnt combinationally in this cycle, and latch the owner's addr, we and wdata.
  - Next state is ISSUE.
  - With no request pending, stay in IDLE.
- Arbitration:
  - Only `d_req` pending: grant data.
  - Only `i_req` pending: grant fetch.
  - Both pending: grant data, unless `starve_cnt == STARVE_LIMIT`, in which case grant fetch.
- Starvation counter (`starve_cnt`):
  - Increments, saturating at STARVE_LIMIT, on a data grant made while `i_req` = 1.
  - Clears on any fetch grant.
  - Clears on a data grant made while `i_req` = 0.
- ISSUE:
  - Drive `m_req` = 1 together with the latched `m_we`, `m_addr` and `m_wdata`.
  - Next state is WAIT, with the latency counter loaded to LATENCY.
- WAIT:
  - Decrement the latency counter each cycle.
  - In the final WAIT cycle, register `m_rdata` into the response register, or 0 for a write.
  - Next state is RESP.
- RESP:
  - Pulse the owner's rvalid with the registered data.
  - Next state is IDLE.
  - No grant is issued in RESP.
- Fetch requests are read-only; `m_we` is forced to 0 for a fetch transaction.
- Address and data widths are fixed at 32 bits, with no arithmetic on addresses.
- Reset mid-operation:
  - Return immediately to IDLE and clear `starve_cnt` and all latches.
  - The in-flight transaction is dropped: no rvalid is issued, and a write already strobed stays in memory.

## Timing
- Reset values: every output is 0, state is IDLE, `starve_cnt` is 0.
- `m_addr`, `m_wdata` and `m_we` are 0 whenever `m_req` = 0.
- Each transaction is counted relative to its grant cycle t:
  - `gnt` at t.
  - `m_req` at t+1.
  - `m_rdata` sampled at the end of t+1+LATENCY.
  - rvalid and rdata at t+2+LATENCY.
  - Earliest next grant at t+3+LATENCY.
- Sustained throughput is one transaction per LATENCY+3 cycles.
- `i_rdata` and `d_rdata` hold their last value outside rvalid cycles; only the rvalid pulses are contractual.
- A requester dropping req before gnt is illegal; behaviour in that case is unspecified.
- A requester may assert req again in its own rvalid cycle. That request is arbitrated in the following IDLE cycle.
- `i_gnt` and `d_gnt` are never high in the same cycle.
- At most one rvalid is high in any cycle.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the owner enum (OWN_I, OWN_D);
  - a 32-bit word-width constant.
- Single module with no sub-module. The latency counter and `starve_cnt` are local registers sized by $clog2 of their parameters.

## Test plan
- Lone fetch, LATENCY=1: `i_req` with `i_addr`=0x40 at cycle 0. Required response:
  - `i_gnt` at 0;
  - `m_req` with `m_addr`=0x40 and `m_we`=0 at 1;
  - `i_rvalid` at 3 with `i_rdata` equal to the memory word;
  - no `d_*` activity.
- Data write then read, LATENCY=2:
  - write 0xDEADBEEF to 0x100: `d_rvalid` at t+4 with `d_rdata`=0.
  - read of 0x100 granted at t+5: `d_rvalid` at t+9 with `d_rdata`=0xDEADBEEF.
- Simultaneous requests with `starve_cnt`=0: `d_gnt` first. `i_gnt` is issued at the next IDLE once `d_req` drops.
- Starvation, STARVE_LIMIT=4: `i_req` and `d_req` held continuously. Required grant order is D, D, D, D, I, D, D, D, D, I.
- Reset mid-operation: assert reset in the WAIT cycle of a data read. Required response:
  - all outputs 0 immediately;
  - no `d_rvalid` ever for that transaction;
  - after release, a fresh `i_req` is served with standard timing.
- Parameter sweep: repeat the lone-fetch test with LATENCY=1, 3 and 8. rvalid must land exactly at t+2+LATENCY.
